raster_csr_resp: RTL

- Consumer/responder end of the raster stamp and CSR path.
- Captures raster_stamp_t records from the rasterizer into a per-warp, per-lane slot array.
- Answers CSR read requests from the core's CSR unit for CSR_RASTER_POS_MASK and CSR_RASTER_BCOORD_{X,Y,Z}{0..3}.
- Sits between the raster unit output and the core's CSR read port.

---
 rtl/raster_csr_resp_pkg.sv | 38 +++
 rtl/raster_csr_resp_decode.sv | 18 +
 rtl/raster_csr_resp.sv | 81 ++++++++
 3 files changed

// File: rtl/raster_csr_resp_pkg.sv
// raster_csr_resp_pkg: raster stamp/CSR types, CSR addresses and pos_mask packing.
package raster_csr_resp_pkg;
  localparam int RASTER_DIM_BITS = 15;
  localparam int RASTER_PID_BITS = 16;
  localparam int CSR_ADDR_BITS = 12;
  localparam int RASTER_CSR_LANE_BITS = 32;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_POS_MASK = 12'hCC0;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_X0 = 12'hCC1;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_X1 = 12'hCC2;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_X2 = 12'hCC3;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_X3 = 12'hCC4;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_Y0 = 12'hCC5;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_Y1 = 12'hCC6;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_Y2 = 12'hCC7;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_Y3 = 12'hCC8;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_Z0 = 12'hCC9;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_Z1 = 12'hCCA;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_Z2 = 12'hCCB;
  localparam logic [CSR_ADDR_BITS-1:0] CSR_RASTER_BCOORD_Z3 = 12'hCCC;
  typedef struct packed {
    logic [RASTER_DIM_BITS-2:0] pos_x;
    logic [RASTER_DIM_BITS-2:0] pos_y;
    logic [3:0] mask;
    logic [3:0][31:0] bcoord_x;
    logic [3:0][31:0] bcoord_y;
    logic [3:0][31:0] bcoord_z;
    logic [RASTER_PID_BITS-1:0] pid;
  } raster_stamp_t;
  typedef struct packed {
    logic [RASTER_CSR_LANE_BITS-1:0] pos_mask;
    logic [3:0][31:0] bcoord_x;
    logic [3:0][31:0] bcoord_y;
    logic [3:0][31:0] bcoord_z;
  } raster_csrs_t;
  function automatic logic [RASTER_CSR_LANE_BITS-1:0] pack_pos_mask(raster_stamp_t s);
    return RASTER_CSR_LANE_BITS'({s.pos_y, s.pos_x, s.mask});
  endfunction
endpackage

// File: rtl/raster_csr_resp_decode.sv
// raster_csr_decode: maps a CSR address onto one 32-bit field of a slot; unknown addresses read 0.
module raster_csr_decode
  import raster_csr_resp_pkg::*;
(
  input  logic [CSR_ADDR_BITS-1:0]        addr_i,
  input  raster_csrs_t                    csrs_i,
  output logic [RASTER_CSR_LANE_BITS-1:0] data_o
);
  always_comb begin
    data_o = '0;
    if (addr_i == CSR_RASTER_POS_MASK) data_o = csrs_i.pos_mask;
    for (int k = 0; k < 4; k++) begin
      if (addr_i == CSR_RASTER_BCOORD_X0 + CSR_ADDR_BITS'(k)) data_o = csrs_i.bcoord_x[k];
      if (addr_i == CSR_RASTER_BCOORD_Y0 + CSR_ADDR_BITS'(k)) data_o = csrs_i.bcoord_y[k];
      if (addr_i == CSR_RASTER_BCOORD_Z0 + CSR_ADDR_BITS'(k)) data_o = csrs_i.bcoord_z[k];
    end
  end
endmodule

// File: rtl/raster_csr_resp.sv
// raster_csr_resp: captures raster stamps per warp/lane and answers CSR reads with 1-cycle latency.
// Optional RASTER_CSR_PERF_EN adds perf_stamps/perf_stalls counters.
module raster_csr_resp
  import raster_csr_resp_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int NUM_LANES = 4,
  localparam int WID_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      stamp_valid,
  output logic                                      stamp_ready,
  input  logic [WID_BITS-1:0]                       stamp_wid,
  input  logic [LANE_BITS-1:0]                      stamp_lane,
  input  raster_stamp_t                             stamp_data,
  input  logic                                      req_valid,
  output logic                                      req_ready,
  input  logic [WID_BITS-1:0]                       req_wid,
  input  logic [CSR_ADDR_BITS-1:0]                  req_addr,
  output logic                                      rsp_valid,
  input  logic                                      rsp_ready,
  output logic [NUM_LANES*RASTER_CSR_LANE_BITS-1:0] rsp_data
`ifdef RASTER_CSR_PERF_EN
  ,
  output logic [43:0]                               perf_stamps,
  output logic [43:0]                               perf_stalls
`endif
);
  raster_csrs_t entry_q [NUM_WARPS][NUM_LANES];
  logic [NUM_WARPS-1:0][NUM_LANES-1:0] valid_q;
  logic rsp_valid_q, rsp_valid_d;
  logic [NUM_LANES*RASTER_CSR_LANE_BITS-1:0] rsp_data_q, rsp_data_d, rd_data;
  logic stamp_fire, req_fire;
  logic unused_pid;
  assign unused_pid = ^stamp_data.pid;
  assign stamp_ready = 1'b1;
  assign req_ready = !rsp_valid_q | rsp_ready;
  assign stamp_fire = stamp_valid & stamp_ready;
  assign req_fire = req_valid & req_ready;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [RASTER_CSR_LANE_BITS-1:0] word;
    raster_csr_decode u_dec (.addr_i(req_addr), .csrs_i(entry_q[req_wid][i]), .data_o(word));
    assign rd_data[i*RASTER_CSR_LANE_BITS +: RASTER_CSR_LANE_BITS] = valid_q[req_wid][i] ? word : '0;
  end
  // Output register refills in the same cycle it drains, so reads stream at 1/cycle.
  assign rsp_valid_d = req_fire | (rsp_valid_q & !rsp_ready);
  assign rsp_data_d = req_fire ? rd_data : rsp_data_q;
  always_ff @(posedge clk)
    if (stamp_fire)
      entry_q[stamp_wid][stamp_lane] <= '{pos_mask: pack_pos_mask(stamp_data),
                                          bcoord_x: stamp_data.bcoord_x,
                                          bcoord_y: stamp_data.bcoord_y,
                                          bcoord_z: stamp_data.bcoord_z};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      if (stamp_fire) valid_q[stamp_wid][stamp_lane] <= 1'b1;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
    end
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
`ifdef RASTER_CSR_PERF_EN
  logic [43:0] perf_stamps_q, perf_stalls_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      perf_stamps_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_stamps_q <= perf_stamps_q + 44'(stamp_fire);
      perf_stalls_q <= perf_stalls_q + 44'(rsp_valid_q & !rsp_ready);
    end
  assign perf_stamps = perf_stamps_q;
  assign perf_stalls = perf_stalls_q;
`endif
endmodule
